// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial MSB-first pattern transmitter with repeats and idle gaps
// Optional macro SEQ_GEN_PARITY_EN appends an even-parity bit after each repetition.
module seq_pattern_gen #(
    parameter int PAT_W   = 4,
    parameter int BIT_CYC = 1,
    parameter int GAP     = 2,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep_cnt,
    output logic             p1,
    output logic             frame,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_GEN_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    localparam int NBITS = PAT_W + PAR_BITS;
    localparam int BCW   = $clog2(NBITS + 1);
    localparam int HCW   = $clog2(BIT_CYC + 1);
    localparam int GCW   = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(NBITS - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(BIT_CYC - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] shift_q, shift_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
    logic             p1_q, p1_d;
    logic             frame_q, frame_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fill_bit;

`ifdef SEQ_GEN_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (state_q == S_IDLE && start) begin
            par_d = ^pat_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    // Parity shifts in behind the pattern so it reaches the MSB right after bit 0.
    assign fill_bit = par_q;
`else
    assign fill_bit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        pat_d      = pat_q;
        rep_d      = rep_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d    = pat_in;
                    pat_d      = pat_in;
                    rep_d      = (rep_cnt == '0) ? CNT_W'(1) : rep_cnt;
                    bit_cnt_d  = '0;
                    hold_cnt_d = '0;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (rep_q > CNT_W'(1)) begin
                            rep_d = rep_q - CNT_W'(1);
                            if (GAP > 0) begin
                                gap_cnt_d = '0;
                                state_d   = S_GAP;
                            end else begin
                                shift_d = pat_q;
                            end
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        shift_d   = {shift_q[PAT_W-2:0], fill_bit};
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d  = '0;
                    shift_d    = pat_q;
                    bit_cnt_d  = '0;
                    hold_cnt_d = '0;
                    state_d    = S_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q + GCW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are precomputed from next state so they come straight off flops.
        p1_d    = (state_d == S_SEND) && shift_d[PAT_W-1];
        frame_d = (state_d == S_SEND);
        busy_d  = (state_d == S_SEND) || (state_d == S_GAP);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            pat_q      <= '0;
            rep_q      <= '0;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            p1_q       <= 1'b0;
            frame_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            pat_q      <= pat_d;
            rep_q      <= rep_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            p1_q       <= p1_d;
            frame_q    <= frame_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign p1    = p1_q;
    assign frame = frame_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - directed self-checking bench for seq_pattern_gen
module tb_seq_pattern_gen;

    logic       clk;
    logic       rst;
    logic       start,   start_b;
    logic [3:0] pat_in,  pat_in_b;
    logic [3:0] rep_cnt, rep_cnt_b;
    logic       p1, frame, busy, done;
    logic       p1_b, frame_b, busy_b, done_b;

    int errors;
    int checks;

    seq_pattern_gen #(.PAT_W(4), .BIT_CYC(1), .GAP(2), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pat_in  (pat_in),
        .rep_cnt (rep_cnt),
        .p1      (p1),
        .frame   (frame),
        .busy    (busy),
        .done    (done)
    );

    seq_pattern_gen #(.PAT_W(4), .BIT_CYC(3), .GAP(0), .CNT_W(4)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .start   (start_b),
        .pat_in  (pat_in_b),
        .rep_cnt (rep_cnt_b),
        .p1      (p1_b),
        .frame   (frame_b),
        .busy    (busy_b),
        .done    (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (p1 !== 1'b0)      begin errors++; $display("FAIL reset_p1 got %b exp 0", p1); end
        checks++; if (frame !== 1'b0)   begin errors++; $display("FAIL reset_frame got %b exp 0", frame); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (p1_b !== 1'b0)    begin errors++; $display("FAIL reset_p1_b got %b exp 0", p1_b); end
        checks++; if (frame_b !== 1'b0) begin errors++; $display("FAIL reset_frame_b got %b exp 0", frame_b); end
        checks++; if (busy_b !== 1'b0)  begin errors++; $display("FAIL reset_busy_b got %b exp 0", busy_b); end
        checks++; if (done_b !== 1'b0)  begin errors++; $display("FAIL reset_done_b got %b exp 0", done_b); end
        rst = 1'b0;
        step();
    endtask

`ifndef SEQ_GEN_PARITY_EN
    task automatic test_basic(input logic [3:0] rc, input string tag);
        logic [5:0] v_p1, v_fr, v_bs, v_dn;
        v_p1 = '0; v_fr = '0; v_bs = '0; v_dn = '0;
        pat_in  = 4'b1100;
        rep_cnt = rc;
        start   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            start = 1'b0;
            v_p1 = {v_p1[4:0], p1};
            v_fr = {v_fr[4:0], frame};
            v_bs = {v_bs[4:0], busy};
            v_dn = {v_dn[4:0], done};
        end
        checks++; if (v_p1 !== 6'b110000) begin errors++; $display("FAIL %s_p1 got %b exp 110000", tag, v_p1); end
        checks++; if (v_fr !== 6'b111100) begin errors++; $display("FAIL %s_frame got %b exp 111100", tag, v_fr); end
        checks++; if (v_bs !== 6'b111100) begin errors++; $display("FAIL %s_busy got %b exp 111100", tag, v_bs); end
        checks++; if (v_dn !== 6'b000010) begin errors++; $display("FAIL %s_done got %b exp 000010", tag, v_dn); end
    endtask

    task automatic test_repeat_gap();
        logic [11:0] v_p1, v_fr, v_bs, v_dn;
        v_p1 = '0; v_fr = '0; v_bs = '0; v_dn = '0;
        pat_in  = 4'b1100;
        rep_cnt = 4'd2;
        start   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            start = 1'b0;
            v_p1 = {v_p1[10:0], p1};
            v_fr = {v_fr[10:0], frame};
            v_bs = {v_bs[10:0], busy};
            v_dn = {v_dn[10:0], done};
        end
        checks++; if (v_p1 !== 12'b110000110000) begin errors++; $display("FAIL rep_p1 got %b exp 110000110000", v_p1); end
        checks++; if (v_fr !== 12'b111100111100) begin errors++; $display("FAIL rep_frame got %b exp 111100111100", v_fr); end
        checks++; if (v_bs !== 12'b111111111100) begin errors++; $display("FAIL rep_busy got %b exp 111111111100", v_bs); end
        checks++; if (v_dn !== 12'b000000000010) begin errors++; $display("FAIL rep_done got %b exp 000000000010", v_dn); end
    endtask

    task automatic test_zero_gap_stretch();
        logic [25:0] v_p1, v_fr, v_bs, v_dn;
        v_p1 = '0; v_fr = '0; v_bs = '0; v_dn = '0;
        pat_in_b  = 4'b1010;
        rep_cnt_b = 4'd2;
        start_b   = 1'b1;
        for (int i = 0; i < 26; i++) begin
            step();
            start_b = 1'b0;
            v_p1 = {v_p1[24:0], p1_b};
            v_fr = {v_fr[24:0], frame_b};
            v_bs = {v_bs[24:0], busy_b};
            v_dn = {v_dn[24:0], done_b};
        end
        checks++; if (v_p1 !== {24'hE38E38, 2'b00}) begin errors++; $display("FAIL zgap_p1 got %h exp %h", v_p1, {24'hE38E38, 2'b00}); end
        checks++; if (v_fr !== {24'hFFFFFF, 2'b00}) begin errors++; $display("FAIL zgap_frame got %h exp %h", v_fr, {24'hFFFFFF, 2'b00}); end
        checks++; if (v_bs !== {24'hFFFFFF, 2'b00}) begin errors++; $display("FAIL zgap_busy got %h exp %h", v_bs, {24'hFFFFFF, 2'b00}); end
        checks++; if (v_dn !== {24'h000000, 2'b10}) begin errors++; $display("FAIL zgap_done got %h exp %h", v_dn, {24'h000000, 2'b10}); end
    endtask

    task automatic test_ignored_inputs();
        logic [11:0] v_p1, v_fr, v_bs, v_dn;
        int n_done;
        v_p1 = '0; v_fr = '0; v_bs = '0; v_dn = '0;
        n_done  = 0;
        pat_in  = 4'b1100;
        rep_cnt = 4'd1;
        start   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 1) pat_in = 4'b1011;
            if (i == 6) start = 1'b0;
            v_p1 = {v_p1[10:0], p1};
            v_fr = {v_fr[10:0], frame};
            v_bs = {v_bs[10:0], busy};
            v_dn = {v_dn[10:0], done};
            if (i < 5 && done) n_done++;
        end
        checks++; if (v_p1 !== 12'b110000101100) begin errors++; $display("FAIL ign_p1 got %b exp 110000101100", v_p1); end
        checks++; if (v_fr !== 12'b111100111100) begin errors++; $display("FAIL ign_frame got %b exp 111100111100", v_fr); end
        checks++; if (v_bs !== 12'b111100111100) begin errors++; $display("FAIL ign_busy got %b exp 111100111100", v_bs); end
        checks++; if (v_dn !== 12'b000010000010) begin errors++; $display("FAIL ign_done got %b exp 000010000010", v_dn); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL ign_first_done_count got %0d exp 1", n_done); end
    endtask
`else
    task automatic test_parity();
        logic [6:0] v_p1, v_fr, v_bs, v_dn;
        v_p1 = '0; v_fr = '0; v_bs = '0; v_dn = '0;
        pat_in  = 4'b1101;
        rep_cnt = 4'd1;
        start   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            start = 1'b0;
            v_p1 = {v_p1[5:0], p1};
            v_fr = {v_fr[5:0], frame};
            v_bs = {v_bs[5:0], busy};
            v_dn = {v_dn[5:0], done};
        end
        checks++; if (v_p1 !== 7'b1101100) begin errors++; $display("FAIL par_p1 got %b exp 1101100", v_p1); end
        checks++; if (v_fr !== 7'b1111100) begin errors++; $display("FAIL par_frame got %b exp 1111100", v_fr); end
        checks++; if (v_bs !== 7'b1111100) begin errors++; $display("FAIL par_busy got %b exp 1111100", v_bs); end
        checks++; if (v_dn !== 7'b0000010) begin errors++; $display("FAIL par_done got %b exp 0000010", v_dn); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [3:0] v_p1, v_fr;
        v_p1 = '0; v_fr = '0;
        pat_in  = 4'b1100;
        rep_cnt = 4'd1;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (p1 !== 1'b0)    begin errors++; $display("FAIL rstmid_p1 got %b exp 0", p1); end
        checks++; if (frame !== 1'b0) begin errors++; $display("FAIL rstmid_frame got %b exp 0", frame); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL rstmid_done got %b exp 0", done); end
        step();
        rst   = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            start = 1'b0;
            v_p1 = {v_p1[2:0], p1};
            v_fr = {v_fr[2:0], frame};
        end
        checks++; if (v_p1 !== 4'b1100) begin errors++; $display("FAIL rstmid_after_p1 got %b exp 1100", v_p1); end
        checks++; if (v_fr !== 4'b1111) begin errors++; $display("FAIL rstmid_after_frame got %b exp 1111", v_fr); end
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        pat_in    = 4'b0000;
        rep_cnt   = 4'd0;
        start_b   = 1'b0;
        pat_in_b  = 4'b0000;
        rep_cnt_b = 4'd0;
        test_reset();
`ifndef SEQ_GEN_PARITY_EN
        test_basic(4'd1, "basic");
        test_repeat_gap();
        test_basic(4'd0, "rep0");
        test_zero_gap_stretch();
        test_ignored_inputs();
`else
        test_parity();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
